reservation_table: RTL and testbench



---
 rtl/resv_pkg.sv | 42 ++++
 rtl/resv_entry.sv | 73 +++++++
 rtl/reservation_table.sv | 114 +++++++++++
 tb/tb_reservation_table.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/resv_pkg.sv
// rtl/resv_pkg.sv - shared defaults, types and address-compare helper for the LR/SC reservation table (optional RESV_TIMEOUT_EN)
package resv_pkg;

  // Default configuration of the table; the top-level parameters start from these.
  localparam int RESV_NUM_THREADS    = 16;
  localparam int RESV_ADDR_WIDTH     = 12;
  localparam int RESV_GRANULE_LOG2   = 2;
  localparam int RESV_TIMEOUT_CYCLES = 64;
  localparam int HART_W              = $clog2(RESV_NUM_THREADS);

  // Widest address the compare helper accepts; callers zero-extend into it.
  localparam int MATCH_W = 64;

`ifdef RESV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RESV_TIMEOUT_CYCLES + 1);
`endif

  // Memory operation seen by the table in one cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    LR   = 2'd1,
    SC   = 2'd2,
    ST   = 2'd3
  } resv_op_e;

  // Contents of one reservation slot in the default configuration.
  typedef struct packed {
    logic                       valid;
    logic [RESV_ADDR_WIDTH-1:0] addr;
`ifdef RESV_TIMEOUT_EN
    logic [CNT_W-1:0]           cnt;
`endif
  } resv_entry_t;

  // Two addresses hit the same reservation granule when they agree above the low g bits.
  function automatic logic granule_match(input logic [MATCH_W-1:0] a,
                                         input logic [MATCH_W-1:0] b,
                                         input int unsigned        g);
    return (a >> g) == (b >> g);
  endfunction

endpackage

// File: rtl/resv_entry.sv
// rtl/resv_entry.sv - one reservation slot: valid bit, reserved address, optional lifetime counter (RESV_TIMEOUT_EN)
module resv_entry
  import resv_pkg::*;
#(
  parameter int ADDR_WIDTH   = RESV_ADDR_WIDTH,
  parameter int GRANULE_LOG2 = RESV_GRANULE_LOG2
`ifdef RESV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = RESV_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_set,
  input  logic                  i_clear,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_match
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  clear_any;

`ifdef RESV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          expire;

  // The LR cycle itself is the first cycle of the lifetime, so the counter starts one
  // below the lifetime and the entry dies on the edge where it would step from 1 to 0.
  assign expire    = valid_q && (cnt_q == CW'(1));
  assign clear_any = i_clear | expire;

  // Lifetime counter: reload on LR, count down while the reservation is held.
  always_ff @(posedge clk) begin
    if (i_set) begin
      cnt_q <= CW'(TIMEOUT_CYCLES - 1);
    end else if (valid_q && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end
`else
  assign clear_any = i_clear;
`endif

  // Valid bit with priority reset > flush > clear > set.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (clear_any) begin
      valid_q <= 1'b0;
    end else if (i_set) begin
      valid_q <= 1'b1;
    end
  end

  // Reserved address is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_set) begin
      addr_q <= i_addr;
    end
  end

  assign o_valid = valid_q;
  assign o_match = valid_q &&
                   granule_match(MATCH_W'(addr_q), MATCH_W'(i_addr), GRANULE_LOG2);

endmodule

// File: rtl/reservation_table.sv
// rtl/reservation_table.sv - per-hart LR/SC reservation table with registered SC result (optional RESV_TIMEOUT_EN)
module reservation_table
  import resv_pkg::*;
#(
  parameter int NUM_THREADS    = RESV_NUM_THREADS,
  parameter int ADDR_WIDTH     = RESV_ADDR_WIDTH,
  parameter int GRANULE_LOG2   = RESV_GRANULE_LOG2,
  parameter int TIMEOUT_CYCLES = RESV_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic                           i_store_op,
  input  logic                           i_store_cond_op,
  input  logic                           i_load_reserved_op,
  input  logic [$clog2(NUM_THREADS)-1:0] i_mhartid,
  input  logic                           i_flush,
  input  logic [$clog2(NUM_THREADS)-1:0] i_flush_hart,
  output logic                           o_sc_success,
  output logic [NUM_THREADS-1:0]         o_resv_valid
);

  // Reject configurations the hart decode or the lifetime counter cannot represent.
  if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_threads
    $error("reservation_table: NUM_THREADS must be a power of two >= 2");
  end
  if (GRANULE_LOG2 < 0 || GRANULE_LOG2 >= ADDR_WIDTH) begin : g_bad_granule
    $error("reservation_table: GRANULE_LOG2 must lie in [0, ADDR_WIDTH)");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("reservation_table: TIMEOUT_CYCLES must be >= 2");
  end

  resv_op_e               op;
  logic [NUM_THREADS-1:0] hart_sel;
  logic [NUM_THREADS-1:0] flush_sel;
  logic [NUM_THREADS-1:0] set_vec;
  logic [NUM_THREADS-1:0] clear_vec;
  logic [NUM_THREADS-1:0] match_vec;
  logic [NUM_THREADS-1:0] valid_vec;
  logic                   sc_hit;
  logic                   sc_success_q;

  // Collapse the three op strobes into one operation code.
  always_comb begin
    op = NONE;
    if (i_load_reserved_op) begin
      op = LR;
    end else if (i_store_cond_op) begin
      op = SC;
    end else if (i_store_op) begin
      op = ST;
    end
  end

  // One-hot select of the issuing hart and of the hart being flushed.
  always_comb begin
    hart_sel               = '0;
    flush_sel              = '0;
    hart_sel[i_mhartid]    = 1'b1;
    flush_sel[i_flush_hart] = i_flush;
  end

  // The SC sees the issuing hart's entry before any flush of this cycle lands.
  assign sc_hit = match_vec[i_mhartid];

  // Per-entry set/clear strobes: LR sets its own entry; SC always drops its own
  // entry and, on success, every other entry covering the same granule; a store
  // drops every entry covering its granule, its own included.
  always_comb begin
    set_vec   = '0;
    clear_vec = '0;
    case (op)
      LR:      set_vec   = hart_sel;
      SC:      clear_vec = hart_sel | (sc_hit ? match_vec : '0);
      ST:      clear_vec = match_vec;
      default: begin
      end
    endcase
  end

  for (genvar e = 0; e < NUM_THREADS; e++) begin : g_entry
    resv_entry #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .GRANULE_LOG2 (GRANULE_LOG2)
`ifdef RESV_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .i_addr  (i_addr),
      .i_set   (set_vec[e]),
      .i_clear (clear_vec[e]),
      .i_flush (flush_sel[e]),
      .o_valid (valid_vec[e]),
      .o_match (match_vec[e])
    );
  end

  // SC result register: a one-cycle pulse after a successful SC, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_success_q <= 1'b0;
    end else begin
      sc_success_q <= (op == SC) && sc_hit;
    end
  end

  assign o_sc_success = sc_success_q;
  assign o_resv_valid = valid_vec;

endmodule

// File: tb/tb_reservation_table.sv
// tb/tb_reservation_table.sv - directed and randomized checks of reservation_table against a behavioural model
module tb_reservation_table;
  import resv_pkg::*;

  localparam int NT = 16;
  localparam int AW = 12;
  localparam int G  = 2;
  localparam int T  = 8;
  localparam int HW = HART_W;

  localparam int OP_NONE = 0;
  localparam int OP_LR   = 1;
  localparam int OP_SC   = 2;
  localparam int OP_ST   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] i_addr = '0;
  logic          i_store_op = 1'b0;
  logic          i_store_cond_op = 1'b0;
  logic          i_load_reserved_op = 1'b0;
  logic [HW-1:0] i_mhartid = '0;
  logic          i_flush = 1'b0;
  logic [HW-1:0] i_flush_hart = '0;
  logic          o_sc_success;
  logic [NT-1:0] o_resv_valid;

  reservation_table #(
    .NUM_THREADS    (NT),
    .ADDR_WIDTH     (AW),
    .GRANULE_LOG2   (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_addr             (i_addr),
    .i_store_op         (i_store_op),
    .i_store_cond_op    (i_store_cond_op),
    .i_load_reserved_op (i_load_reserved_op),
    .i_mhartid          (i_mhartid),
    .i_flush            (i_flush),
    .i_flush_hart       (i_flush_hart),
    .o_sc_success       (o_sc_success),
    .o_resv_valid       (o_resv_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: one reservation per hart plus the cycle on which it was taken.
  resv_entry_t   m_ent [NT];
  int            m_lr  [NT];
  int            cyc = 0;
  logic          exp_success = 1'b0;
  logic [NT-1:0] exp_valid = '0;
  bit            chk_en = 1'b0;

  function automatic bit same_granule(input int a, input int b);
    return (a >> G) == (b >> G);
  endfunction

  // Apply one cycle of inputs to the model, the way the table's rules describe it.
  function automatic void model_update(input int op, input int h, input int a,
                                       input bit fl, input int fh, input bit rst);
    bit hit;
    bit clr;
    if (rst) begin
      for (int e = 0; e < NT; e++) m_ent[e].valid = 1'b0;
      exp_success = 1'b0;
    end else begin
      hit = (op == OP_SC) && m_ent[h].valid && same_granule(int'(m_ent[h].addr), a);
      for (int e = 0; e < NT; e++) begin
        clr = 1'b0;
        if (op == OP_SC && e == h) clr = 1'b1;
        if (op == OP_SC && hit && m_ent[e].valid && same_granule(int'(m_ent[e].addr), a)) clr = 1'b1;
        if (op == OP_ST && m_ent[e].valid && same_granule(int'(m_ent[e].addr), a)) clr = 1'b1;
`ifdef RESV_TIMEOUT_EN
        if (m_ent[e].valid && (cyc - m_lr[e] == T - 1)) clr = 1'b1;
`endif
        if (fl && e == fh) begin
          m_ent[e].valid = 1'b0;
        end else if (clr) begin
          m_ent[e].valid = 1'b0;
        end else if (op == OP_LR && e == h) begin
          m_ent[e].valid = 1'b1;
          m_ent[e].addr  = AW'(a);
          m_lr[e]        = cyc;
        end
      end
      exp_success = hit;
    end
    for (int e = 0; e < NT; e++) exp_valid[e] = m_ent[e].valid;
    cyc++;
  endfunction

  // Drive one cycle of stimulus, advance the model on the edge, then settle.
  task automatic step(input int op, input int h, input int a,
                      input bit fl, input int fh, input bit rst);
    @(negedge clk);
    reset              = rst;
    i_addr             = AW'(a);
    i_load_reserved_op = (op == OP_LR);
    i_store_cond_op    = (op == OP_SC);
    i_store_op         = (op == OP_ST);
    i_mhartid          = HW'(h);
    i_flush            = fl;
    i_flush_hart       = HW'(fh);
    @(posedge clk);
    model_update(op, h, a, fl, fh, rst);
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_NONE, 0, 0, 1'b0, 0, 1'b0);
  endtask

  // Hand-computed expectation, applied both to the DUT and to the model.
  task automatic pin(input string name, input logic got_dut, input logic got_model, input logic want);
    checks++;
    if (got_dut !== want) begin
      errors++;
      $display("FAIL %s dut=%b required=%b", name, got_dut, want);
    end
    checks++;
    if (got_model !== want) begin
      errors++;
      $display("FAIL %s model=%b required=%b", name, got_model, want);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (o_sc_success !== exp_success) begin
        errors++;
        $display("FAIL sc_success cyc=%0d got=%b required=%b", cyc, o_sc_success, exp_success);
      end
      checks++;
      if (o_resv_valid !== exp_valid) begin
        errors++;
        $display("FAIL resv_valid cyc=%0d got=%h required=%h", cyc, o_resv_valid, exp_valid);
      end
    end
  end

  // Ops must be one-hot-or-zero.
  always @(posedge clk) begin
    if (!$onehot0({i_store_op, i_store_cond_op, i_load_reserved_op})) begin
      errors++;
      $display("FAIL op_onehot store=%b sc=%b lr=%b", i_store_op, i_store_cond_op, i_load_reserved_op);
    end
  end

  initial begin
    int op, h, a, fh;
    bit fl, rst;

    for (int e = 0; e < NT; e++) begin
      m_ent[e] = '0;
      m_lr[e]  = 0;
    end

    step(OP_NONE, 0, 0, 1'b0, 0, 1'b1);
    step(OP_NONE, 0, 0, 1'b0, 0, 1'b1);
    pin("reset_success", o_sc_success, exp_success, 1'b0);
    pin("reset_valid_zero", o_resv_valid == '0, exp_valid == '0, 1'b1);

    step(OP_NONE, 0, 0, 1'b0, 0, 1'b0);

    // LR/SC pair on one hart
    step(OP_LR, 3, 'h100, 1'b0, 0, 1'b0);
    step(OP_SC, 3, 'h100, 1'b0, 0, 1'b0);
    pin("pair_success", o_sc_success, exp_success, 1'b1);
    pin("pair_valid3", o_resv_valid[3], exp_valid[3], 1'b0);
    idle(1);
    pin("pulse_not_held", o_sc_success, exp_success, 1'b0);

    // Store in the same granule kills both reservations
    step(OP_LR, 3, 'h100, 1'b0, 0, 1'b0);
    step(OP_LR, 5, 'h100, 1'b0, 0, 1'b0);
    pin("two_lr_valid3", o_resv_valid[3], exp_valid[3], 1'b1);
    pin("two_lr_valid5", o_resv_valid[5], exp_valid[5], 1'b1);
    step(OP_ST, 7, 'h102, 1'b0, 0, 1'b0);
    pin("store_clr3", o_resv_valid[3], exp_valid[3], 1'b0);
    pin("store_clr5", o_resv_valid[5], exp_valid[5], 1'b0);
    step(OP_SC, 3, 'h100, 1'b0, 0, 1'b0);
    pin("sc_after_store", o_sc_success, exp_success, 1'b0);

    // Independent entries
    step(OP_LR, 1, 'h040, 1'b0, 0, 1'b0);
    step(OP_LR, 2, 'h080, 1'b0, 0, 1'b0);
    step(OP_SC, 2, 'h080, 1'b0, 0, 1'b0);
    pin("indep_sc2", o_sc_success, exp_success, 1'b1);
    step(OP_SC, 1, 'h040, 1'b0, 0, 1'b0);
    pin("indep_sc1", o_sc_success, exp_success, 1'b1);

    // Flush beats LR on the same hart
    step(OP_LR, 4, 'h010, 1'b1, 4, 1'b0);
    pin("flush_lr_valid4", o_resv_valid[4], exp_valid[4], 1'b0);
    step(OP_SC, 4, 'h010, 1'b0, 0, 1'b0);
    pin("flush_lr_sc", o_sc_success, exp_success, 1'b0);

    // Wrong-granule SC fails and still drops the reservation
    step(OP_LR, 0, 'h200, 1'b0, 0, 1'b0);
    step(OP_SC, 0, 'h204, 1'b0, 0, 1'b0);
    pin("miss_sc", o_sc_success, exp_success, 1'b0);
    pin("miss_valid0", o_resv_valid[0], exp_valid[0], 1'b0);
    step(OP_SC, 0, 'h200, 1'b0, 0, 1'b0);
    pin("miss_retry", o_sc_success, exp_success, 1'b0);

    // SC sees pre-flush state of its own entry
    step(OP_LR, 9, 'h0A0, 1'b0, 0, 1'b0);
    step(OP_SC, 9, 'h0A0, 1'b1, 9, 1'b0);
    pin("sc_flush_success", o_sc_success, exp_success, 1'b1);
    pin("sc_flush_valid9", o_resv_valid[9], exp_valid[9], 1'b0);

    // Flush of another hart is independent of the op
    step(OP_LR, 10, 'h0B0, 1'b0, 0, 1'b0);
    step(OP_LR, 11, 'h0C0, 1'b1, 10, 1'b0);
    pin("xflush_valid10", o_resv_valid[10], exp_valid[10], 1'b0);
    pin("xflush_valid11", o_resv_valid[11], exp_valid[11], 1'b1);

    // Reset between LR and SC
    step(OP_LR, 12, 'h0D0, 1'b0, 0, 1'b0);
    step(OP_NONE, 0, 0, 1'b0, 0, 1'b1);
    step(OP_SC, 12, 'h0D0, 1'b0, 0, 1'b0);
    pin("reset_mid_sc", o_sc_success, exp_success, 1'b0);

    // Own store clears own entry
    step(OP_LR, 13, 'h0E0, 1'b0, 0, 1'b0);
    step(OP_ST, 13, 'h0E3, 1'b0, 0, 1'b0);
    pin("own_store_valid13", o_resv_valid[13], exp_valid[13], 1'b0);

`ifdef RESV_TIMEOUT_EN
    // SC on the last live cycle succeeds
    step(OP_LR, 6, 'h300, 1'b0, 0, 1'b0);
    idle(6);
    pin("to_alive_valid6", o_resv_valid[6], exp_valid[6], 1'b1);
    step(OP_SC, 6, 'h300, 1'b0, 0, 1'b0);
    pin("to_sc_t_minus_1", o_sc_success, exp_success, 1'b1);
    // SC one cycle later fails; valid drops exactly T cycles after the LR
    step(OP_LR, 6, 'h300, 1'b0, 0, 1'b0);
    idle(6);
    pin("to_valid6_before", o_resv_valid[6], exp_valid[6], 1'b1);
    idle(1);
    pin("to_valid6_dropped", o_resv_valid[6], exp_valid[6], 1'b0);
    step(OP_SC, 6, 'h300, 1'b0, 0, 1'b0);
    pin("to_sc_t", o_sc_success, exp_success, 1'b0);
`endif

    // Randomized traffic over a handful of granules
    for (int i = 0; i < 3000; i++) begin
      op  = $urandom_range(0, 9);
      op  = (op < 4) ? OP_LR : (op < 7) ? OP_SC : (op < 8) ? OP_ST : OP_NONE;
      h   = $urandom_range(0, NT - 1);
      a   = 'h100 + ($urandom_range(0, 4) << G) + $urandom_range(0, (1 << G) - 1);
      fl  = ($urandom_range(0, 7) == 0);
      fh  = (fl && $urandom_range(0, 1) == 0) ? h : $urandom_range(0, NT - 1);
      rst = ($urandom_range(0, 299) == 0);
      step(op, h, a, fl, fh, rst);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
